// File: rtl/xvc_drain_arb.sv
// xvc_drain_arb: read-side drain arbiter for the tagged multi-VC FIFO.
// Round-robins among VCs that have a head flit and downstream credit, pops the
// winner with a one-cycle read pulse and parks its head word in a single
// registered output link (valid/ready). Owns the per-VC downstream credit
// counters and a sticky credit-overflow flag.
module xvc_drain_arb #(
    parameter int VCN     = 8,
    parameter int D       = 11,
    parameter int CREDITS = 4,
    localparam int TW     = $clog2(VCN),
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic               i_clk,
    input  logic               i_sreset,
    input  logic [VCN*D-1:0]   i_fifo_dout,
    input  logic [VCN-1:0]     i_fifo_empty_n,
    output logic [VCN-1:0]     o_fifo_re,
    output logic               o_out_vld,
    output logic [D-1:0]       o_out_data,
    output logic [TW-1:0]      o_out_vc,
    input  logic               i_out_rdy,
    input  logic [VCN-1:0]     i_credit_ret,
    output logic               o_credit_ovf
);

    // Registered state
    logic [VCN-1:0][CW-1:0] r_credit;
    logic [TW-1:0]          r_ptr;
    logic                   r_out_vld;
    logic [D-1:0]           r_out_data;
    logic [TW-1:0]          r_out_vc;
    logic                   r_credit_ovf;

    // Combinational helpers
    logic [VCN-1:0]         w_elig;
    logic [VCN-1:0]         w_grant_oh;
    logic [VCN-1:0]         w_inc;
    logic [VCN-1:0]         w_dec;
    logic [VCN-1:0]         w_ovf_hit;
    logic [VCN-1:0][CW-1:0] w_credit_next;
    logic                   w_slot_free;
    logic                   w_found;
    logic                   w_grant;
    logic [TW-1:0]          w_win;
    logic [TW:0]            w_idx;
    logic [TW-1:0]          w_ptr_next;
    logic [D-1:0]           w_head;

    // The output slot can take a new flit if it is empty or being drained now.
    assign w_slot_free = ~r_out_vld | i_out_rdy;

    // Per-VC eligibility, one-hot grant decode and credit bookkeeping.
    // A same-cycle return and grant cancel out; a lone return at full credit
    // saturates the counter and raises the overflow flag instead.
    generate
        for (genvar gi = 0; gi < VCN; gi++) begin : g_vc
            assign w_elig[gi]        = i_fifo_empty_n[gi] & (r_credit[gi] != '0);
            assign w_grant_oh[gi]    = w_grant & (w_win == TW'(gi));
            assign w_ovf_hit[gi]     = i_credit_ret[gi] & ~w_grant_oh[gi]
                                       & (r_credit[gi] == CW'(CREDITS));
            assign w_inc[gi]         = i_credit_ret[gi] & ~w_grant_oh[gi]
                                       & (r_credit[gi] != CW'(CREDITS));
            assign w_dec[gi]         = w_grant_oh[gi] & ~i_credit_ret[gi];
            assign w_credit_next[gi] = w_inc[gi] ? r_credit[gi] + CW'(1) :
                                       w_dec[gi] ? r_credit[gi] - CW'(1) :
                                                   r_credit[gi];
        end
    endgenerate

    // Rotating priority search starting at the pointer; the index wraps at VCN
    // explicitly so non-power-of-two channel counts rotate correctly.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < VCN; k++) begin
            w_idx = {1'b0, r_ptr} + (TW+1)'(k);
            if (w_idx >= (TW+1)'(VCN)) begin
                w_idx = w_idx - (TW+1)'(VCN);
            end
            if (!w_found && w_elig[w_idx[TW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[TW-1:0];
            end
        end
    end

    assign w_grant    = w_slot_free & w_found;
    assign w_ptr_next = (w_win == TW'(VCN - 1)) ? '0 : w_win + TW'(1);
    assign w_head     = i_fifo_dout[w_win*D +: D];

    // Read pulse is suppressed while reset is held so the FIFO never pops
    // during or straight out of an asynchronous reset.
    assign o_fifo_re    = w_grant_oh & {VCN{~i_sreset}};
    assign o_out_vld    = r_out_vld;
    assign o_out_data   = r_out_data;
    assign o_out_vc     = r_out_vc;
    assign o_credit_ovf = r_credit_ovf;

    // Credit counters: start full, then track grants and returns.
    always_ff @(posedge i_clk or posedge i_sreset) begin
        if (i_sreset) begin
            r_credit <= {VCN{CW'(CREDITS)}};
        end else begin
            r_credit <= w_credit_next;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_sreset) begin
        if (i_sreset) begin
            r_credit_ovf <= 1'b0;
        end else if (|w_ovf_hit) begin
            r_credit_ovf <= 1'b1;
        end
    end

    // Round-robin pointer moves just past the winner on every grant.
    always_ff @(posedge i_clk or posedge i_sreset) begin
        if (i_sreset) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Output link register: load on grant, drop valid when drained with no
    // refill, otherwise hold the flit untouched under backpressure.
    always_ff @(posedge i_clk or posedge i_sreset) begin
        if (i_sreset) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_vc   <= '0;
        end else if (w_grant) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_head;
            r_out_vc   <= w_win;
        end else if (i_out_rdy) begin
            r_out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xvc_drain_arb.sv
// Directed bench for xvc_drain_arb: a behavioural FIFO feeds the arbiter, a
// reference arbiter model predicts each read pulse, and predicted flits go
// through a scoreboard queue that is checked when the output link drains.
module tb_xvc_drain_arb;
    localparam int VCN     = 8;
    localparam int D       = 11;
    localparam int CREDITS = 4;
    localparam int TW      = 3;
    localparam int FD      = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [VCN*D-1:0]   fifo_dout;
    logic [VCN-1:0]     fifo_empty_n;
    logic [VCN-1:0]     fifo_re;
    logic               out_vld;
    logic [D-1:0]       out_data;
    logic [TW-1:0]      out_vc;
    logic               out_rdy;
    logic [VCN-1:0]     credit_ret;
    logic               credit_ovf;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural FIFO contents per VC
    logic [D-1:0] fmem [VCN][FD];
    int fhead [VCN];
    int fcnt  [VCN];

    // Reference model state
    int   m_ptr;
    int   m_credit [VCN];
    logic m_out_vld;
    logic m_ovf;
    logic [TW+D-1:0] sb [$];

    // Observations from the DUT
    logic [VCN-1:0] obs_re;
    int ghist [$];

    always #5 clk = ~clk;

    xvc_drain_arb #(.VCN(VCN), .D(D), .CREDITS(CREDITS)) dut (
        .i_clk          (clk),
        .i_sreset       (rst),
        .i_fifo_dout    (fifo_dout),
        .i_fifo_empty_n (fifo_empty_n),
        .o_fifo_re      (fifo_re),
        .o_out_vld      (out_vld),
        .o_out_data     (out_data),
        .o_out_vc       (out_vc),
        .i_out_rdy      (out_rdy),
        .i_credit_ret   (credit_ret),
        .o_credit_ovf   (credit_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int v = 0; v < VCN; v++) begin
            fifo_empty_n[v] = (fcnt[v] > 0);
            fifo_dout[v*D +: D] = (fcnt[v] > 0) ? fmem[v][fhead[v]] : '0;
        end
    endtask

    task automatic push(input int v, input logic [D-1:0] data);
        fmem[v][(fhead[v] + fcnt[v]) % FD] = data;
        fcnt[v]++;
        drive_inputs();
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_out_vld = 1'b0;
        m_ovf = 1'b0;
        for (int v = 0; v < VCN; v++) m_credit[v] = CREDITS;
        sb.delete();
    endtask

    // One clock: predict and check at the falling edge, then advance the
    // model and FIFO just after the rising edge.
    task automatic cycle();
        bit found;
        bit grant;
        int g;
        int idx;
        logic [VCN-1:0] exp_re;
        @(negedge clk);
        found = 0;
        g = 0;
        for (int k = 0; k < VCN; k++) begin
            idx = (m_ptr + k) % VCN;
            if (!found && fcnt[idx] > 0 && m_credit[idx] != 0) begin
                found = 1;
                g = idx;
            end
        end
        grant = found && (!m_out_vld || out_rdy);
        exp_re = grant ? (VCN'(1) << g) : '0;
        obs_re = fifo_re;
        for (int v = 0; v < VCN; v++) if (fifo_re[v]) ghist.push_back(v);
        $display("t=%0t re=%b vld=%b vc=%0d data=%h rdy=%b ret=%b ovf=%b",
                 $time, fifo_re, out_vld, out_vc, out_data, out_rdy, credit_ret, credit_ovf);
        chk("fifo_re", 32'(fifo_re), 32'(exp_re));
        chk("out_vld", 32'(out_vld), 32'(m_out_vld));
        if (m_out_vld) begin
            chk("out_flit", 32'({out_vc, out_data}), (sb.size() > 0) ? 32'(sb[0]) : 32'hDEAD);
            if (out_rdy && sb.size() > 0) void'(sb.pop_front());
        end
        chk("credit_ovf", 32'(credit_ovf), 32'(m_ovf));
        if (grant) sb.push_back({TW'(g), fmem[g][fhead[g]]});
        @(posedge clk);
        #1;
        for (int v = 0; v < VCN; v++) begin
            if (credit_ret[v] && !(grant && g == v)) begin
                if (m_credit[v] == CREDITS) m_ovf = 1'b1;
                else m_credit[v]++;
            end else if ((grant && g == v) && !credit_ret[v]) begin
                m_credit[v]--;
            end
        end
        if (grant) begin
            m_out_vld = 1'b1;
            m_ptr = (g + 1) % VCN;
            fhead[g] = (fhead[g] + 1) % FD;
            fcnt[g]--;
        end else if (out_rdy) begin
            m_out_vld = 1'b0;
        end
        credit_ret = '0;
        drive_inputs();
    endtask

    function automatic int count_vc(input int v);
        int n = 0;
        foreach (ghist[i]) if (ghist[i] == v) n++;
        return n;
    endfunction

    initial begin
        for (int v = 0; v < VCN; v++) begin
            fhead[v] = 0;
            fcnt[v] = 0;
        end
        credit_ret = '0;
        out_rdy = 1'b1;
        drive_inputs();
        model_reset();

        // Reset state
        #7;
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_re", 32'(fifo_re), 32'd0);
        chk("rst_ovf", 32'(credit_ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // FIFO init window: nothing to drain
        repeat (2) cycle();

        // Single VC: three back-to-back pops of VC3
        push(3, 11'h101); push(3, 11'h102); push(3, 11'h103);
        ghist.delete();
        cycle(); chk("single_re0", 32'(obs_re), 32'h08);
        cycle(); chk("single_re1", 32'(obs_re), 32'h08);
        cycle(); chk("single_re2", 32'(obs_re), 32'h08);
        cycle(); chk("single_re3", 32'(obs_re), 32'h00);
        cycle();
        chk("single_cnt", 32'(count_vc(3)), 32'd3);

        // Round-robin: steer ptr to 0 via a VC7 grant, then 0/2/7 twice each
        push(7, 11'h070);
        cycle(); cycle();
        push(0, 11'h001); push(0, 11'h002);
        push(2, 11'h021); push(2, 11'h022);
        push(7, 11'h071); push(7, 11'h072);
        ghist.delete();
        repeat (8) cycle();
        chk("rr_n", 32'(ghist.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            int exp_vc;
            exp_vc = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 7;
            chk("rr_order", (ghist.size() > i) ? 32'(ghist[i]) : 32'hFFFF, 32'(exp_vc));
        end

        // Credit exhaustion on VC1, then a single return
        for (int i = 0; i < 8; i++) push(1, 11'h110 + 11'(i));
        ghist.delete();
        repeat (8) cycle();
        chk("exhaust_cnt", 32'(count_vc(1)), 32'd4);
        credit_ret = 8'h02;
        cycle(); chk("ret_same_cyc", 32'(obs_re), 32'h00);
        cycle(); chk("ret_next_cyc", 32'(obs_re), 32'h02);
        cycle(); chk("ret_after", 32'(obs_re), 32'h00);

        // Backpressure on VC5, then pass-through refill as out_rdy rises
        push(5, 11'h501); push(5, 11'h502); push(5, 11'h503);
        cycle(); chk("bp_first", 32'(obs_re), 32'h20);
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(); chk("bp_hold_re", 32'(obs_re), 32'h00);
        end
        out_rdy = 1'b1;
        cycle(); chk("bp_refill", 32'(obs_re), 32'h20);
        repeat (3) cycle();

        // Simultaneous grant and return on VC4 at credit 2
        push(4, 11'h401); push(4, 11'h402);
        cycle(); cycle();
        push(4, 11'h403);
        credit_ret = 8'h10;
        cycle(); chk("both_re", 32'(obs_re), 32'h10);
        push(4, 11'h404); push(4, 11'h405); push(4, 11'h406);
        ghist.delete();
        repeat (5) cycle();
        chk("both_cnt", 32'(count_vc(4)), 32'd2);

        // Return to a full counter on VC6
        credit_ret = 8'h40;
        cycle();
        cycle(); chk("ovf_set", 32'(credit_ovf), 32'd1);
        cycle(); chk("ovf_sticky", 32'(credit_ovf), 32'd1);

        // Reset mid-stream with a flit parked in the output register
        push(0, 11'h0A1); push(0, 11'h0A2);
        cycle(); chk("pre_rst_re", 32'(obs_re), 32'h01);
        out_rdy = 1'b0;
        cycle();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_re", 32'(fifo_re), 32'd0);
        chk("mid_rst_ovf", 32'(credit_ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        out_rdy = 1'b1;
        ghist.delete();
        repeat (8) cycle();
        chk("post_rst_first", (ghist.size() > 0) ? 32'(ghist[0]) : 32'hFFFF, 32'd0);
        chk("post_rst_vc1", 32'(count_vc(1)), 32'd3);
        chk("post_rst_ovf", 32'(credit_ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
